// File: rtl/sm4_top_if.sv
// Command/result bundle between a bus wrapper (master) and the SM4 core (slave).
// en is a one-cycle start strobe; done is a one-cycle completion strobe.
interface sm4_top_if;
  logic         en;
  logic         mode;
  logic [127:0] intext;
  logic [127:0] key;
  logic [127:0] outtext;
  logic         done;

  modport master (output en, mode, intext, key, input outtext, done);
  modport slave  (input en, mode, intext, key, output outtext, done);
endinterface

// File: rtl/sm4_top.sv
// Iterative SM4 core: 32 key-expansion cycles into a round-key file, then 32 data rounds.
// Optional macro SM4_KEY_CACHE_EN skips key expansion when the key matches the last expanded key.
module sm4_top (
  input  logic       clk,
  input  logic       rst,
  sm4_top_if.slave   bus,
  output logic [1:0] dbg_state
);

  // Handshake: en is honoured only in IDLE; operands are captured on that edge.
  // done pulses for one cycle, outtext holds until the next completion.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] ROUND  = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  localparam logic [127:0] FK = 128'hA3B1BAC656AA3350677D9197B27022DC;

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] l_data(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  logic [1:0]   state;
  logic [4:0]   cnt;
  logic         mode_q;
  logic [127:0] k_q;
  logic [127:0] x_q;
  logic [31:0]  rk [32];
  logic [127:0] out_q;
  logic         done_q;

  logic [7:0]   ck_base;
  logic [31:0]  ck;
  logic [31:0]  rk_new;
  logic [31:0]  rk_sel;
  logic [31:0]  x_new;
  logic         cache_hit;

  always_comb begin
    ck_base = {1'b0, cnt, 2'b00};
    ck      = {8'(ck_base * 8'd7), 8'((ck_base + 8'd1) * 8'd7),
               8'((ck_base + 8'd2) * 8'd7), 8'((ck_base + 8'd3) * 8'd7)};
    rk_new  = k_q[127:96] ^ l_key(tau(k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck));
    // Decryption walks the same key schedule backwards: 31 - r is ~r on 5 bits.
    rk_sel  = rk[mode_q ? cnt : ~cnt];
    x_new   = x_q[127:96] ^ l_data(tau(x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_sel));
  end

`ifdef SM4_KEY_CACHE_EN
  logic         cache_valid;
  logic [127:0] cached_key;

  assign cache_hit = cache_valid && (bus.key == cached_key);

  // The key file is overwritten during expansion, so validity drops until it finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cached_key  <= '0;
    end else if (state == IDLE && bus.en && !cache_hit) begin
      cache_valid <= 1'b0;
      cached_key  <= bus.key;
    end else if (state == KEYEXP && cnt == 5'd31) begin
      cache_valid <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      k_q    <= '0;
      x_q    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 32; i++) rk[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            mode_q <= bus.mode;
            x_q    <= bus.intext;
            cnt    <= '0;
            if (cache_hit) begin
              state <= ROUND;
            end else begin
              k_q   <= bus.key ^ FK;
              state <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          rk[cnt] <= rk_new;
          k_q     <= {k_q[95:0], rk_new};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ROUND;
        end
        ROUND: begin
          x_q <= {x_q[95:0], x_new};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIN;
        end
        default: begin
          out_q  <= {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};
          done_q <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.outtext = out_q;
  assign bus.done    = done_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_sm4_top.sv
// Directed and randomized checks of sm4_top against a word-array SM4 reference model.
module tb_sm4_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  sm4_top_if bus();

  sm4_top dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  localparam logic [127:0] KAT_PT = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KAT_CT = 128'h681EDF34D206965E86B3E94F536E4246;

  int checks = 0;
  int errors = 0;
  int cyc;
  int done_cnt;

  logic [7:0]   sbox_tab [256];
  bit           cache_feature;
  bit           cache_valid;
  logic [127:0] cache_key;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_tab[v[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_sm4(input logic [127:0] k, input logic [127:0] blk, input bit enc);
    logic [31:0] fk [4];
    logic [31:0] kk [36];
    logic [31:0] x  [36];
    logic [31:0] ck, b, rkv;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int i = 0; i < 4; i++) begin
      kk[i] = k[127 - 32*i -: 32] ^ fk[i];
      x[i]  = blk[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      b = sub_word(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
      kk[i+4] = kk[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
    end
    for (int r = 0; r < 32; r++) begin
      rkv = enc ? kk[r+4] : kk[35-r];
      b = sub_word(x[r+1] ^ x[r+2] ^ x[r+3] ^ rkv);
      x[r+4] = x[r] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic int exp_latency(input logic [127:0] k);
    return (cache_feature && cache_valid && k == cache_key) ? 33 : 65;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] t, input bit m);
    bus.en = 1'b1; bus.key = k; bus.intext = t; bus.mode = m;
    tick();
    bus.en = 1'b0;
    cyc = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(output logic [127:0] res);
    do tick(); while (bus.done !== 1'b1 && cyc < 300);
    res = bus.outtext;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_done", {127'b0, bus.done}, 128'b0);
    chk("rst_out", bus.outtext, 128'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cache_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] t,
                        input bit m, output logic [127:0] res);
    int lat;
    lat = exp_latency(k);
    start_op(k, t, m);
    wait_done(res);
    chk({tag, "_lat"}, 128'(cyc), 128'(lat));
    chk({tag, "_out"}, res, ref_sm4(k, t, m));
    cache_valid = 1'b1;
    cache_key = k;
    tick();
    chk({tag, "_pulse"}, {127'b0, bus.done}, 128'b0);
  endtask

  initial begin
    logic [2047:0] st;
    logic [127:0]  res, k2, k_last;
    int            inj, lat;

    st = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
    for (int i = 0; i < 256; i++) sbox_tab[i] = st[2047 - 8*i -: 8];
`ifdef SM4_KEY_CACHE_EN
    cache_feature = 1'b1;
`else
    cache_feature = 1'b0;
`endif
    cache_valid = 1'b0;
    cache_key   = '0;
    cyc = 0;
    done_cnt = 0;

    // Reset state
    bus.en = 1'b0; bus.mode = 1'b0; bus.intext = '0; bus.key = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_done", {127'b0, bus.done}, 128'b0);
    chk("init_out", bus.outtext, 128'b0);
    rst = 1'b0;
    tick();

    // Known-answer encrypt and decrypt
    run_op("enc_kat", KAT_PT, KAT_PT, 1'b1, res);
    chk("enc_kat_const", res, KAT_CT);
    run_op("dec_kat", KAT_PT, KAT_CT, 1'b0, res);
    chk("dec_kat_const", res, KAT_PT);

    // en with different operands during ROUND must be ignored
    lat = exp_latency(KAT_PT);
    inj = lat - 20;
    start_op(KAT_PT, KAT_PT, 1'b1);
    while (cyc < inj) tick();
    bus.en = 1'b1; bus.key = rand128(); bus.intext = rand128(); bus.mode = 1'b0;
    tick();
    bus.en = 1'b0;
    wait_done(res);
    chk("ign_lat", 128'(cyc), 128'(lat));
    chk("ign_out", res, KAT_CT);
    repeat (3) tick();
    chk("ign_done_count", 128'(done_cnt), 128'd1);

    // Reset during ROUND aborts; fresh op afterwards is correct
    k2 = rand128();
    start_op(k2, KAT_PT, 1'b1);
    while (cyc < 40) tick();
    do_reset();
    run_op("after_rst", KAT_PT, KAT_PT, 1'b1, res);
    chk("after_rst_const", res, KAT_CT);

    // Reset during key expansion leaves no usable cached key
    start_op(k2, KAT_PT, 1'b0);
    while (cyc < 20) tick();
    do_reset();
    run_op("keyexp_rst", k2, KAT_PT, 1'b0, res);

    // Back-to-back: decrypt of the result starts the cycle after done
    run_op("b2b_enc", KAT_PT, KAT_PT, 1'b1, res);
    chk("b2b_enc_const", res, KAT_CT);
    run_op("b2b_dec", KAT_PT, res, 1'b0, res);
    chk("b2b_dec_const", res, KAT_PT);

    // Randomized operations, sometimes reusing the previous key
    k_last = KAT_PT;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 0) k_last = rand128();
      run_op("rand", k_last, rand128(), 1'($urandom_range(0, 1)), res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
